pipe_reg_elastic: RTL

Parametrised elastic pipeline register for the next-generation pipelined CPU. It replaces the fixed, always-advancing stage register with a DEPTH-stage chain that has a valid/ready handshake, a two-entry skid buffer per stage, synchronous flush and an occupancy count. It sits between CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB) so that stalls from multi-cycle memory or hazards propagate without data loss, and so that mispredicted-branch flushes can clear in-flight work.

---
 rtl/pipe_reg_elastic.sv | 99 +++++++++
 1 files changed

// File: rtl/pipe_reg_elastic.sv
// Elastic DEPTH-stage pipeline register. Each stage has a main register and a skid register.
// Ready comes only from registered state, so no combinational path runs from out_ready_i to in_ready_o.
module pipe_reg_elastic #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0,
   localparam int CW = $clog2(2*DEPTH+1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] data_o,
   output logic [CW-1:0]    count_o
);

   generate
      if (DEPTH < 1) begin : g_depth_check
         $error("pipe_reg_elastic: DEPTH must be at least 1");
      end
   endgenerate

   // Index k is the input side of stage k. Index DEPTH is the chain output.
   logic [DEPTH:0]   stg_valid;
   logic [DEPTH:0]   stg_ready;
   logic [WIDTH-1:0] stg_data [DEPTH+1];

   logic          in_fire;
   logic          out_fire;
   logic [CW-1:0] count_reg;

   assign stg_valid[0]     = in_valid_i;
   assign stg_data[0]      = data_i;
   assign stg_ready[DEPTH] = out_ready_i;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         logic             vld_m_reg;
         logic             vld_s_reg;
         logic [WIDTH-1:0] dat_m_reg;
         logic [WIDTH-1:0] dat_s_reg;
         logic             in_xfer;
         logic             out_xfer;

         assign in_xfer            = stg_valid[gi] & stg_ready[gi];
         assign out_xfer           = vld_m_reg & stg_ready[gi+1];
         assign stg_ready[gi]      = ~vld_s_reg;
         assign stg_valid[gi+1]    = vld_m_reg;
         assign stg_data[gi+1]     = dat_m_reg;

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               vld_m_reg <= 1'b0;
               vld_s_reg <= 1'b0;
               dat_m_reg <= RST_VAL;
               dat_s_reg <= RST_VAL;
            end else if (flush_i) begin
               vld_m_reg <= 1'b0;
               vld_s_reg <= 1'b0;
            end else if (out_xfer && vld_s_reg) begin
               // The skid only fills while ready is low, so no input arrives here.
               dat_m_reg <= dat_s_reg;
               vld_s_reg <= 1'b0;
            end else if (in_xfer && (!vld_m_reg || out_xfer)) begin
               dat_m_reg <= stg_data[gi];
               vld_m_reg <= 1'b1;
            end else if (in_xfer) begin
               dat_s_reg <= stg_data[gi];
               vld_s_reg <= 1'b1;
            end else if (out_xfer) begin
               vld_m_reg <= 1'b0;
            end
         end
      end
   endgenerate

   assign in_ready_o  = ~rst_i & stg_ready[0];
   assign out_valid_o = stg_valid[DEPTH];
   assign data_o      = stg_data[DEPTH];
   assign in_fire     = in_valid_i & in_ready_o;
   assign out_fire    = out_valid_o & out_ready_i;
   assign count_o     = count_reg;

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         count_reg <= '0;
      end else if (in_fire && !out_fire) begin
         count_reg <= count_reg + CW'(1);
      end else if (out_fire && !in_fire) begin
         count_reg <= count_reg - CW'(1);
      end
   end

endmodule
